mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multicycle MIPS main control unit, the sequential successor to the single-cycle opcode decoder. A Moore FSM walks each instruction through fetch/decode/execute/memory/writeback and drives datapath enables, ALU selects and PC-source selects. It stalls on a memory-ready handshake and raises precise exceptions for illegal opcode, arithmetic overflow and an external interrupt. It sits between the instruction register / ALU flags and the shared-memory multicycle datapath.

## Interface
- EXT_OPS, 1: 1 adds `addi` (001000) and `bne` (000101) to the legal set; 0 makes them illegal.
- IRQ_EN, 1: 1 enables the external-interrupt path; 0 ignores `ext_irq`.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- op  in  6  opcode from the IR, stable from DECODE until the instruction ends.
- of  in  1  ALU signed overflow, valid in EXEC/ADDIEX.
- mem_ready  in  1  memory completes the current access this cycle.
- ext_irq  in  1  level interrupt request.
- pc_write, pc_write_cond, branch_ne, iord, mem_rd, mem_wr, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
- epc_write, cause_write, cpu_int  out  1 each  exception controls.
- int_cause  out  2  registered cause: 00 illegal opcode, 01 overflow, 10 external irq.

## Operation
- States (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RTYPEWB, BRANCH, JUMP, ADDIEX, ADDIWB, EXCEPT.
- Outputs default to 0; each state asserts only the outputs listed below.
- FETCH: mem_rd=1, alu_src_b=01. ir_write=pc_write=mem_ready. Stays in FETCH while !mem_ready, then goes to DECODE.
- DECODE: alu_src_b=11. Next state by op:
  - 000000 → EXEC
  - 100011 / 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - EXT_OPS: 001000 → ADDIEX, 000101 → BRANCH
  - any other op → EXCEPT with cause 00.
- MEMADR: alu_src_a=1, alu_src_b=10. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_rd=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1.
- MEMWR: mem_wr=1, iord=1. Waits for mem_ready.
- EXEC: alu_src_a=1, alu_op=10. of=1 → EXCEPT with cause 01 (writeback suppressed); otherwise RTYPEWB.
- RTYPEWB: reg_write=1, reg_dst=1.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(op==000101).
- JUMP: pc_write=1, pc_source=10.
- ADDIEX: alu_src_a=1, alu_src_b=10. of=1 → EXCEPT with cause 01; otherwise ADDIWB.
- ADDIWB: reg_write=1.
- EXCEPT: epc_write=1, cause_write=1, cpu_int=1, pc_write=1, pc_source=11. Lasts one cycle, then goes to FETCH. EPC captures the already-incremented PC.
- irq_pending flag:
  - Sets on any clk with ext_irq=1 and IRQ_EN=1.
  - Checked on every transition that would enter FETCH (MEMWB, MEMWR-done, RTYPEWB, BRANCH, JUMP, ADDIWB, EXCEPT). If set, next state is EXCEPT with cause 10 and irq_pending clears on that edge. A new ext_irq on the same edge wins, so the flag stays set.
- Exception priority: illegal/overflow are detected in DECODE/EXEC, so they always precede a pending irq. The irq is taken immediately after that EXCEPT, before the next fetch.
- int_cause register loads only on the edge entering EXCEPT and holds otherwise.

## Timing
- Reset state is FETCH; irq_pending=0, int_cause=00.
- While rst=1 all outputs are forced to 0, including mem_rd in FETCH.
- Minimum cycle counts with mem_ready=1 throughout:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type, addi | 4 |
  | beq, bne, j | 3 |
  | Exception | +1 (EXCEPT) |

- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. mem_rd/mem_wr/iord stay asserted and stable throughout the wait.
- rst mid-instruction: on the next edge the FSM returns to FETCH. No writes complete after the reset edge.

## Test plan
- Reset, then lw (op=100011) with mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. reg_write=mem_to_reg=1 only in cycle 5.
- sw with mem_ready held low 3 cycles in MEMWR: mem_wr=iord=1 for 4 consecutive cycles. No other write enable fires.
- R-type with of=1 in EXEC: next state EXCEPT. reg_write never asserted. int_cause=01, epc_write=cause_write=pc_write=1, pc_source=11 for one cycle.
- op=001000 with EXT_OPS=0: EXCEPT with cause 00. Same op with EXT_OPS=1: ADDIEX then ADDIWB, reg_write=1, reg_dst=0.
- ext_irq pulsed 1 cycle during MEMRD of a lw: lw completes its writeback, then EXCEPT with cause 10, then FETCH. irq_pending reads 0 afterwards.
- bne (op=000101) under EXT_OPS=1: BRANCH with pc_write_cond=1, branch_ne=1, alu_op=01. Under beq, branch_ne=0.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle main control FSM and its datapath.
// master drives the datapath controls, slave supplies opcode and status.
interface mc_ctrl_fsm_if;
    logic [5:0] op;
    logic       of;
    logic       mem_ready;
    logic       ext_irq;

    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       epc_write;
    logic       cause_write;
    logic       cpu_int;
    logic [1:0] int_cause;

    modport master (
        input  op, of, mem_ready, ext_irq,
        output pc_write, pc_write_cond, branch_ne,
        output iord, mem_rd, mem_wr, ir_write,
        output mem_to_reg, reg_dst, reg_write,
        output alu_src_a, alu_src_b, alu_op,
        output pc_source, epc_write, cause_write,
        output cpu_int, int_cause
    );

    modport slave (
        output op, of, mem_ready, ext_irq,
        input  pc_write, pc_write_cond, branch_ne,
        input  iord, mem_rd, mem_wr, ir_write,
        input  mem_to_reg, reg_dst, reg_write,
        input  alu_src_a, alu_src_b, alu_op,
        input  pc_source, epc_write, cause_write,
        input  cpu_int, int_cause
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control: Moore FSM with memory stalls,
// precise illegal-op / overflow exceptions and a latched interrupt.
module mc_ctrl_fsm #(
    parameter int EXT_OPS = 1,
    parameter int IRQ_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    mc_ctrl_fsm_if.master     bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_EXCEPT  = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam logic EXT = (EXT_OPS != 0);
    localparam logic IEN = (IRQ_EN != 0);

    state_t     state;
    state_t     state_nx;
    logic       irq_pending;
    logic       irq_set;
    logic       take_irq;
    logic       to_fetch;
    logic [1:0] cause_nx;
    logic [1:0] int_cause_r;

    logic is_r, is_mem, is_beq, is_j, is_addi, is_bne;

    assign is_r    = (bus.op == OP_R);
    assign is_mem  = (bus.op == OP_LW) || (bus.op == OP_SW);
    assign is_beq  = (bus.op == OP_BEQ);
    assign is_j    = (bus.op == OP_J);
    assign is_addi = EXT && (bus.op == OP_ADDI);
    assign is_bne  = EXT && (bus.op == OP_BNE);

    assign irq_set  = IEN && bus.ext_irq;
    assign take_irq = to_fetch && irq_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            irq_pending <= 1'b0;
            int_cause_r <= 2'b00;
        end else begin
            state       <= state_nx;
            // a fresh request on the taking edge keeps the flag set
            irq_pending <= irq_set || (irq_pending && !take_irq);
            if (state_nx == S_EXCEPT)
                int_cause_r <= cause_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cause_nx = 2'b00;
        to_fetch = 1'b0;
        unique case (state)
            S_FETCH:
                if (bus.mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_r:           state_nx = S_EXEC;
                    is_mem:         state_nx = S_MEMADR;
                    is_beq, is_bne: state_nx = S_BRANCH;
                    is_j:           state_nx = S_JUMP;
                    is_addi:        state_nx = S_ADDIEX;
                    default: begin
                        state_nx = S_EXCEPT;
                        cause_nx = 2'b00;
                    end
                endcase
            end
            S_MEMADR:
                state_nx = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:
                if (bus.mem_ready) state_nx = S_MEMWB;
            S_MEMWR:
                to_fetch = bus.mem_ready;
            S_EXEC, S_ADDIEX: begin
                if (bus.of) begin
                    state_nx = S_EXCEPT;
                    cause_nx = 2'b01;
                end else begin
                    state_nx = (state == S_EXEC) ? S_RTYPEWB : S_ADDIWB;
                end
            end
            S_MEMWB, S_RTYPEWB, S_BRANCH,
            S_JUMP, S_ADDIWB, S_EXCEPT:
                to_fetch = 1'b1;
            default:
                state_nx = S_FETCH;
        endcase
        if (to_fetch) begin
            if (irq_pending) begin
                state_nx = S_EXCEPT;
                cause_nx = 2'b10;
            end else begin
                state_nx = S_FETCH;
            end
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_rd        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.epc_write     = 1'b0;
        bus.cause_write   = 1'b0;
        bus.cpu_int       = 1'b0;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    bus.mem_rd    = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE:
                    bus.alu_src_b = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    bus.mem_rd = 1'b1;
                    bus.iord   = 1'b1;
                end
                S_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_wr = 1'b1;
                    bus.iord   = 1'b1;
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                S_RTYPEWB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    bus.branch_ne     = (bus.op == OP_BNE);
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                end
                S_ADDIWB:
                    bus.reg_write = 1'b1;
                S_EXCEPT: begin
                    bus.epc_write   = 1'b1;
                    bus.cause_write = 1'b1;
                    bus.cpu_int     = 1'b1;
                    bus.pc_write    = 1'b1;
                    bus.pc_source   = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign bus.int_cause = rst ? 2'b00 : int_cause_r;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Random-stimulus bench for mc_ctrl_fsm: two configurations checked
// against a per-instruction step-plan model built from opcode rules.
module tb_mc_ctrl_fsm;
    logic clk;
    logic rst;

    logic [5:0] op_r  [2];
    logic       of_r  [2];
    logic       mr_r  [2];
    logic       irq_r [2];
    logic [19:0] ctl  [2];
    logic [1:0]  cse  [2];

    mc_ctrl_fsm_if b0 ();
    mc_ctrl_fsm_if b1 ();

    mc_ctrl_fsm #(.EXT_OPS(1), .IRQ_EN(1)) dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    mc_ctrl_fsm #(.EXT_OPS(0), .IRQ_EN(0)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    assign b0.op = op_r[0];
    assign b0.of = of_r[0];
    assign b0.mem_ready = mr_r[0];
    assign b0.ext_irq = irq_r[0];
    assign b1.op = op_r[1];
    assign b1.of = of_r[1];
    assign b1.mem_ready = mr_r[1];
    assign b1.ext_irq = irq_r[1];

    assign ctl[0] = {b0.pc_write, b0.pc_write_cond, b0.branch_ne,
                     b0.iord, b0.mem_rd, b0.mem_wr, b0.ir_write,
                     b0.mem_to_reg, b0.reg_dst, b0.reg_write,
                     b0.alu_src_a, b0.alu_src_b, b0.alu_op,
                     b0.pc_source, b0.epc_write, b0.cause_write,
                     b0.cpu_int};
    assign ctl[1] = {b1.pc_write, b1.pc_write_cond, b1.branch_ne,
                     b1.iord, b1.mem_rd, b1.mem_wr, b1.ir_write,
                     b1.mem_to_reg, b1.reg_dst, b1.reg_write,
                     b1.alu_src_a, b1.alu_src_b, b1.alu_op,
                     b1.pc_source, b1.epc_write, b1.cause_write,
                     b1.cpu_int};
    assign cse[0] = b0.int_cause;
    assign cse[1] = b1.int_cause;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // instruction steps; the three exception steps carry their cause
    localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SWB = 4;
    localparam int SMW = 5, SEX = 6, SRW = 7, SBR = 8, SJP = 9;
    localparam int SAX = 10, SAW = 11, SE0 = 12, SE1 = 13, SE2 = 14;

    int nchk;
    int nerr;
    int cyc;

    int plan [2][8];
    int pos  [2];
    int len  [2];
    bit pend [2];
    logic [1:0] mcause [2];
    logic [5:0] opn    [2];
    bit ext  [2];
    bit ien  [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] exp_ctl(input int s, input bit mr,
                                            input logic [5:0] op);
        logic pw, pwc, bne, iord, rd, wr, irw, m2r, rdst, rw, a;
        logic [1:0] b, aop, psrc;
        logic epc, cw, ci;
        {pw, pwc, bne, iord, rd, wr, irw, m2r, rdst, rw, a} = '0;
        {b, aop, psrc} = '0;
        {epc, cw, ci} = '0;
        case (s)
            SF:  begin rd = 1; b = 2'b01; irw = mr; pw = mr; end
            SD:  b = 2'b11;
            SMA: begin a = 1; b = 2'b10; end
            SMR: begin rd = 1; iord = 1; end
            SWB: begin rw = 1; m2r = 1; end
            SMW: begin wr = 1; iord = 1; end
            SEX: begin a = 1; aop = 2'b10; end
            SRW: begin rw = 1; rdst = 1; end
            SBR: begin
                a = 1; aop = 2'b01; pwc = 1; psrc = 2'b01;
                bne = (op == 6'b000101);
            end
            SJP: begin pw = 1; psrc = 2'b10; end
            SAX: begin a = 1; b = 2'b10; end
            SAW: rw = 1;
            default: begin
                epc = 1; cw = 1; ci = 1; pw = 1; psrc = 2'b11;
            end
        endcase
        return {pw, pwc, bne, iord, rd, wr, irw, m2r, rdst, rw,
                a, b, aop, psrc, epc, cw, ci};
    endfunction

    task automatic add(input int k, input int s);
        plan[k][len[k]] = s;
        len[k]++;
    endtask

    task automatic new_instr(input int k);
        logic [5:0] ops [8];
        logic [5:0] o;
        ops[0] = 6'b000000; ops[1] = 6'b100011;
        ops[2] = 6'b101011; ops[3] = 6'b000100;
        ops[4] = 6'b000010; ops[5] = 6'b001000;
        ops[6] = 6'b000101; ops[7] = 6'($urandom);
        o = ops[$urandom_range(0, 7)];
        opn[k] = o;
        pos[k] = 0;
        len[k] = 0;
        add(k, SF);
        add(k, SD);
        if (o == 6'b000000) begin
            add(k, SEX); add(k, SRW);
        end else if (o == 6'b100011) begin
            add(k, SMA); add(k, SMR); add(k, SWB);
        end else if (o == 6'b101011) begin
            add(k, SMA); add(k, SMW);
        end else if (o == 6'b000100 || (ext[k] && o == 6'b000101)) begin
            add(k, SBR);
        end else if (o == 6'b000010) begin
            add(k, SJP);
        end else if (ext[k] && o == 6'b001000) begin
            add(k, SAX); add(k, SAW);
        end else begin
            add(k, SE0);
        end
    endtask

    task automatic check_cycle(input int k);
        int s;
        s = plan[k][pos[k]];
        if (rst) begin
            chk($sformatf("rst_ctl%0d c%0d", k, cyc), 32'(ctl[k]), 0);
            chk($sformatf("rst_cause%0d c%0d", k, cyc), 32'(cse[k]), 0);
        end else begin
            chk($sformatf("ctl%0d s%0d c%0d", k, s, cyc), 32'(ctl[k]),
                32'(exp_ctl(s, mr_r[k], op_r[k])));
            chk($sformatf("cause%0d c%0d", k, cyc), 32'(cse[k]),
                32'(mcause[k]));
        end
    endtask

    task automatic model_edge(input int k);
        int s;
        bit adv;
        bit take;
        if (rst) begin
            pend[k] = 0;
            mcause[k] = 2'b00;
            new_instr(k);
            return;
        end
        s = plan[k][pos[k]];
        adv = !((s == SF || s == SMR || s == SMW) && !mr_r[k]);
        take = 0;
        if (adv) begin
            pos[k]++;
            if ((s == SEX || s == SAX) && of_r[k]) begin
                plan[k][0] = SE1; pos[k] = 0; len[k] = 1;
            end
            if (pos[k] == len[k] && pend[k]) begin
                plan[k][0] = SE2; pos[k] = 0; len[k] = 1;
                take = 1;
            end
        end
        pend[k] = (irq_r[k] && ien[k]) || (pend[k] && !take);
        if (adv && pos[k] < len[k] && plan[k][pos[k]] >= SE0)
            mcause[k] = 2'(plan[k][pos[k]] - SE0);
        if (pos[k] == len[k])
            new_instr(k);
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        ext[0] = 1; ien[0] = 1;
        ext[1] = 0; ien[1] = 0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            op_r[k] = '0; of_r[k] = 0; mr_r[k] = 1; irq_r[k] = 0;
            pend[k] = 0; mcause[k] = 2'b00;
            new_instr(k);
        end
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check_cycle(k);
                model_edge(k);
            end
            @(posedge clk);
            #1;
            rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
            for (int k = 0; k < 2; k++) begin
                mr_r[k]  = ($urandom_range(0, 9) < 7);
                of_r[k]  = ($urandom_range(0, 3) == 0);
                irq_r[k] = ($urandom_range(0, 14) == 0);
                op_r[k]  = opn[k];
            end
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end
endmodule
